// File: rtl/seq_pkg.sv
// seq_pkg: shared encodings for the serial pattern generator and the
// 3-state one-hot sequence detector it drives.
//   det_state_t : detector states IDLE / STATE_1 / FINAL (one-hot)
//   gen_state_t : generator states GEN_IDLE / GEN_RUN / GEN_GAP (one-hot)
// Both are 3-bit one-hot; any other encoding is treated as illegal and
// recovers to the respective idle state on the next clock.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    STATE_1 = 3'b010,
    FINAL   = 3'b100
  } det_state_t;

  typedef enum logic [2:0] {
    GEN_IDLE = 3'b001,
    GEN_RUN  = 3'b010,
    GEN_GAP  = 3'b100
  } gen_state_t;

endpackage

// File: rtl/seq_det_model.sv
// seq_det_model: behavioural copy of the 3-state one-hot sequence detector,
// used by seq_pattern_gen to predict the detector outputs for the bit
// stream it is producing. It tracks consecutive 1s on a_i:
//   IDLE    --1--> STATE_1 --1--> FINAL --1--> FINAL, any 0 -> IDLE.
// Ports:
//   clk    in  clock, posedge
//   rst    in  synchronous active-high reset (state -> IDLE)
//   a_i    in  serial input bit (the generator's a_out)
//   out1_o out state == STATE_1
//   out2_o out state == FINAL
// The module only exists when GEN_EXPECT_EN is defined, which is also the
// only build in which the generator instantiates it.
`ifdef GEN_EXPECT_EN
module seq_det_model
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  output logic out1_o,
  output logic out2_o
);

  det_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = a_i ? STATE_1 : IDLE;
      STATE_1: state_d = a_i ? FINAL   : IDLE;
      FINAL:   state_d = a_i ? FINAL   : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out1_o = (state_q == STATE_1);
  assign out2_o = (state_q == FINAL);

endmodule
`endif

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial stimulus source for the one-hot sequence
// detector. Each accepted request produces run_len cycles of a_out=1,
// then gap_len cycles of a_out=0, then a one-cycle done pulse in idle.
// Ports:
//   clk        in   clock, posedge
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  high in GEN_IDLE only (depends on state alone)
//   run_len    in   [CNT_W] count of 1 cycles, sampled at accept
//   gap_len    in   [CNT_W] count of trailing 0 cycles, sampled at accept
//   abort      in   end the current pattern without done; blocks accept in idle
//   a_out      out  registered serial bit
//   busy       out  state != GEN_IDLE
//   done       out  one-cycle pulse on normal completion
//   exp_out1   out  predicted detector out1   (GEN_EXPECT_EN only)
//   exp_out2   out  predicted detector out2   (GEN_EXPECT_EN only)
// Configuration macro: GEN_EXPECT_EN adds the exp_out ports and an internal
// detector model fed by a_out; generator behaviour is the same either way.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] run_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic             abort,
  output logic             a_out,
  output logic             busy,
  output logic             done
`ifdef GEN_EXPECT_EN
  ,
  output logic             exp_out1,
  output logic             exp_out2
`endif
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  gen_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             a_out_q, a_out_d;
  logic             done_q, done_d;
  logic             accept;

  assign req_ready = (state_q == GEN_IDLE);
  assign busy      = (state_q != GEN_IDLE);
  // abort in idle suppresses the handshake even though req_ready is high
  assign accept    = req_valid & req_ready & ~abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GEN_IDLE;
      cnt_q   <= CNT_ZERO;
      gap_q   <= CNT_ZERO;
      a_out_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      a_out_q <= a_out_d;
      done_q  <= done_d;
    end
  end

  // The counter is loaded with the length of the phase being entered and
  // the phase ends when it reads 1; zero-length phases are skipped at load
  // time, so the counter never decrements through zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    case (state_q)
      GEN_IDLE: begin
        if (accept) begin
          gap_d = gap_len;
          if (run_len != CNT_ZERO) begin
            state_d = GEN_RUN;
            cnt_d   = run_len;
          end else if (gap_len != CNT_ZERO) begin
            state_d = GEN_GAP;
            cnt_d   = gap_len;
          end else begin
            cnt_d  = CNT_ZERO;
            done_d = 1'b1;
          end
        end
      end
      GEN_RUN: begin
        if (abort) begin
          state_d = GEN_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q <= CNT_ONE) begin
          if (gap_q != CNT_ZERO) begin
            state_d = GEN_GAP;
            cnt_d   = gap_q;
          end else begin
            state_d = GEN_IDLE;
            cnt_d   = CNT_ZERO;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GEN_GAP: begin
        if (abort) begin
          state_d = GEN_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = GEN_IDLE;
          cnt_d   = CNT_ZERO;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = GEN_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // a_out is registered alongside the state so it is high exactly in GEN_RUN
  assign a_out_d = (state_d == GEN_RUN);

  assign a_out = a_out_q;
  assign done  = done_q;

`ifdef GEN_EXPECT_EN
  seq_det_model u_det_model (
    .clk    (clk),
    .rst    (rst),
    .a_i    (a_out_q),
    .out1_o (exp_out1),
    .out2_o (exp_out2)
  );
`endif

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] gap_len;
  logic             abort;
  logic             a_out;
  logic             busy;
  logic             done;
`ifdef GEN_EXPECT_EN
  logic             exp_out1;
  logic             exp_out2;
`endif

  seq_pattern_gen #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .run_len   (run_len),
    .gap_len   (gap_len),
    .abort     (abort),
    .a_out     (a_out),
    .busy      (busy),
    .done      (done)
`ifdef GEN_EXPECT_EN
    ,
    .exp_out1  (exp_out1),
    .exp_out2  (exp_out2)
`endif
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle
  typedef struct {
    logic a;
    logic bsy;
    logic dn;
  } exp_t;

  exp_t q[$];     // future cycles of the pattern in progress
  exp_t cur;      // expectation for the current cycle
  logic h1, h2;   // a_out of the previous two cycles (since reset)

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_now();
    chk("a_out", a_out, cur.a);
    chk("busy", busy, cur.bsy);
    chk("done", done, cur.dn);
    chk("req_ready", req_ready, ~cur.bsy);
`ifdef GEN_EXPECT_EN
    // detector sees two 1s in a row -> FINAL, a lone latest 1 -> STATE_1
    chk("exp_out1", exp_out1, h1 & ~h2);
    chk("exp_out2", exp_out2, h1 & h2);
`endif
  endtask

  // Check the current cycle, then advance the model using the inputs
  // currently driven, clock once, and move to the next expectation.
  task automatic step();
    exp_t nxt;
    check_now();
    if (rst) begin
      q.delete();
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      h2 = h1;
      h1 = cur.a;
      if (cur.bsy && abort) begin
        q.delete();
      end else if (!cur.bsy && req_valid && !abort) begin
        for (int i = 0; i < int'(run_len); i++) q.push_back('{1'b1, 1'b1, 1'b0});
        for (int i = 0; i < int'(gap_len); i++) q.push_back('{1'b0, 1'b1, 1'b0});
        q.push_back('{1'b0, 1'b0, 1'b1});
      end
    end
    if (q.size() > 0) nxt = q.pop_front();
    else              nxt = '{1'b0, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    cur = nxt;
  endtask

  task automatic send(input int r, input int g);
    rst       = 1'b0;
    abort     = 1'b0;
    req_valid = 1'b1;
    run_len   = CNT_W'(r);
    gap_len   = CNT_W'(g);
    step();
    req_valid = 1'b0;
    // changing the lengths after accept must not disturb the pattern
    run_len   = CNT_W'($urandom);
    gap_len   = CNT_W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    abort     = 1'b0;
    run_len   = '0;
    gap_len   = '0;
    h1        = 1'b0;
    h2        = 1'b0;
    @(posedge clk);
    #1;
    cur = '{1'b0, 1'b0, 1'b0};
    // reset state, with req_valid asserted during reset
    req_valid = 1'b1;
    run_len   = 8'd3;
    step();
    req_valid = 1'b0;
    rst       = 1'b0;
    idle(2);

    // R=3, G=2
    send(3, 2);
    idle(7);

    // R=0,G=0 then R=0,G=4
    send(0, 0);
    idle(2);
    send(0, 4);
    idle(6);

    // R=5,G=0 aborted two cycles in
    send(5, 0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    idle(3);

    // req_valid together with abort in idle: no accept
    req_valid = 1'b1;
    abort     = 1'b1;
    run_len   = 8'd2;
    gap_len   = 8'd1;
    step();
    req_valid = 1'b0;
    abort     = 1'b0;
    idle(3);

    // reset in the middle of an R=4 pattern, then a normal pattern
    send(4, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(2);
    send(3, 2);
    idle(7);

    // R=4 pattern for the detector prediction
    send(4, 2);
    idle(8);

    // back-to-back R=2,G=0 with req_valid held
    req_valid = 1'b1;
    run_len   = 8'd2;
    gap_len   = 8'd0;
    idle(4);
    req_valid = 1'b0;
    idle(4);

    // R=1,G=1 and the maximum lengths
    send(1, 1);
    idle(4);
    send(255, 255);
    idle(515);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      abort     = ($urandom_range(0, 24) == 0);
      req_valid = ($urandom_range(0, 1) == 1);
      run_len   = CNT_W'($urandom_range(0, 5));
      gap_len   = CNT_W'($urandom_range(0, 3));
      step();
    end
    rst       = 1'b0;
    abort     = 1'b0;
    req_valid = 1'b0;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
